// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the spm product collector.
package spm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} spm_coll_state_t;

  // LAT is limited to 1..15, so a 4-bit down-counter covers the WAIT phase.
  localparam int LAT_CNT_W = 4;

  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/spm_sipo.sv
// LSB-first serial-in/parallel-out shift register: new bits enter at the MSB and move right.
module spm_sipo #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         sin,
  output logic [N-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {sin, data[N-1:1]};
    end
  end

endmodule

// File: rtl/spm_product_collector.sv
// Rebuilds the 2*WIDTH-bit product from spm's LSB-first serial stream and offers it on a
// valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for a start pulse
//   WAIT  | start seen, counting down the LAT-1 cycles before the first p bit
//   SHIFT | sampling p into the shift register, one bit per cycle
//   DONE  | product held on prod until the consumer takes it
module spm_product_collector
  import spm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 p,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic                 busy,
  output logic                 start_drop
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]        LAST_IDX = CW'(PW - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'((LAT > 1) ? (LAT - 2) : 0);
  localparam spm_coll_state_t      LAUNCH_STATE = (LAT > 1) ? WAIT : SHIFT;

  spm_coll_state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [PW-1:0]        sr;
  logic [PW-1:0]        sr_next;
  logic                 sr_clear;
  logic                 sr_shift;
  logic                 prod_load;
  logic                 drop_nxt;
  logic                 handshake;
  logic                 last_sample;

  assign prod_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign handshake   = prod_valid & prod_ready;
  assign last_sample = (cnt == LAST_IDX);
  // The final product includes the bit arriving in the last SHIFT cycle.
  assign sr_next     = {p, sr[PW-1:1]};

  spm_sipo #(.N(PW)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (sr_shift),
    .clear    (sr_clear),
    .sin      (p),
    .data     (sr)
  );

  always_comb begin
    state_nxt = state;
    sr_clear  = 1'b0;
    sr_shift  = 1'b0;
    prod_load = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LAUNCH_STATE;
          sr_clear  = 1'b1;
        end
      end
      WAIT: begin
        drop_nxt = start;
        if (lat_cnt == '0) state_nxt = SHIFT;
      end
      SHIFT: begin
        drop_nxt = start;
        sr_shift = 1'b1;
        if (last_sample) begin
          prod_load = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (handshake) begin
          if (start) begin
            state_nxt = LAUNCH_STATE;
            sr_clear  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          drop_nxt = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_cnt    <= '0;
      prod       <= '0;
      start_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_drop <= drop_nxt;
      if (sr_clear) begin
        cnt     <= '0;
        lat_cnt <= LAT_LOAD;
      end else begin
        if (sr_shift) cnt <= cnt + 1'b1;
        if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      end
      if (prod_load) prod <= sr_next;
    end
  end

endmodule

// File: tb/tb_spm_product_collector.sv
// Scoreboard bench for spm_product_collector with WIDTH=4, one instance at LAT=1 and one at LAT=3.
module tb_spm_product_collector;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic p = 1'b0;
  logic prod_ready = 1'b1;
  logic sel = 1'b0;

  logic [PW-1:0] prod1, prod3;
  logic          pv1, pv3, busy1, busy3, sd1, sd3;

  logic [PW-1:0] psel;
  logic          vsel, bsel, sdsel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int a, b;

  typedef struct {
    logic [PW-1:0] val;
    int            at;
    int            hold;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spm_product_collector #(.WIDTH(W), .LAT(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p          (p),
    .prod       (prod1),
    .prod_valid (pv1),
    .prod_ready (prod_ready),
    .busy       (busy1),
    .start_drop (sd1)
  );

  spm_product_collector #(.WIDTH(W), .LAT(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p          (p),
    .prod       (prod3),
    .prod_valid (pv3),
    .prod_ready (prod_ready),
    .busy       (busy3),
    .start_drop (sd3)
  );

  assign psel  = sel ? prod3 : prod1;
  assign vsel  = sel ? pv3   : pv1;
  assign bsel  = sel ? busy3 : busy1;
  assign sdsel = sel ? sd3   : sd1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      start = 1'b0;
    end
  endtask

  // Launch one multiply; dup_at >= 0 raises a second start during that SHIFT bit.
  task automatic issue(input int lat, input logic [PW-1:0] val, input int hold, input int dup_at);
    exp_t e;
    step();
    start = 1'b1;
    p     = 1'($urandom);
    e.val  = val;
    e.at   = cyc + lat + PW;
    e.hold = hold;
    sb.push_back(e);
    for (int i = 1; i < lat; i++) begin
      step();
      start = 1'b0;
      p     = 1'($urandom);
    end
    for (int i = 0; i < PW; i++) begin
      step();
      start = (i == dup_at);
      p     = val[i];
      if (dup_at >= 0 && i == dup_at + 1) check("drop_pulse", 64'(sdsel), 64'd1);
      if (dup_at >= 0 && i == dup_at + 2) check("drop_single", 64'(sdsel), 64'd0);
    end
    start = 1'b0;
  endtask

  // Start a multiply and reset it while sample 3 is on p.
  task automatic abort_run(input logic [PW-1:0] val);
    step();
    start = 1'b1;
    p     = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      p     = val[i];
    end
    step();
    rst = 1'b1;
    p   = val[3];
    step();
    rst = 1'b0;
    check("abort_prod", 64'(psel), 64'd0);
    check("abort_valid", 64'(vsel), 64'd0);
    check("abort_busy", 64'(bsel), 64'd0);
    check("abort_drop", 64'(sdsel), 64'd0);
  endtask

  logic          mon_pv   = 1'b0;
  logic [PW-1:0] mon_prev = '0;
  int            mon_len  = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_pv  = 1'b0;
      mon_len = 0;
    end else begin
      if (vsel) begin
        if (!mon_pv) begin
          mon_len = 0;
          if (sb.size() == 0) check("unexpected_product", 64'd1, 64'd0);
          else check("valid_cycle", 64'(cyc), 64'(sb[0].at));
        end else begin
          check("prod_stable", 64'(psel), 64'(mon_prev));
        end
        mon_len++;
        if (prod_ready && sb.size() > 0) begin
          check("prod_value", 64'(psel), 64'(sb[0].val));
          check("valid_len", 64'(mon_len), 64'(sb[0].hold));
          void'(sb.pop_front());
        end
      end
      mon_pv   = vsel;
      mon_prev = psel;
    end
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_prod", 64'(prod1), 64'd0);
    check("rst_valid", 64'(pv1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_drop", 64'(sd1), 64'd0);
    check("rst_valid3", 64'(pv3), 64'd0);
    check("rst_busy3", 64'(busy3), 64'd0);

    // 5*3
    issue(1, 8'h0F, 1, -1);
    idle(3);

    // 15*15 with a stalled consumer and a start arriving while DONE is stalled
    prod_ready = 1'b0;
    issue(1, 8'hE1, 6, -1);
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_drop", 64'(sdsel), 64'd1);
    step();
    step();
    prod_ready = 1'b1;
    idle(3);

    // 5*7 with a second start during SHIFT
    issue(1, 8'h23, 1, 3);
    idle(4);

    // back-to-back: 6*7, 9*13, 15*14
    issue(1, 8'h2A, 1, -1);
    issue(1, 8'h75, 1, -1);
    issue(1, 8'hD2, 1, -1);
    idle(3);

    // reset mid-SHIFT, then a clean 3*11
    abort_run(8'h0F);
    idle(2);
    issue(1, 8'h21, 1, -1);
    idle(3);

    for (int k = 0; k < 5; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      issue(1, PW'(a * b), 1, -1);
      idle(2);
    end

    // LAT=3 instance: garbage p bits before the data must be ignored
    rst = 1'b1;
    sel = 1'b1;
    step();
    step();
    rst = 1'b0;
    issue(3, 8'h8F, 1, -1);
    idle(4);
    issue(3, 8'h31, 1, -1);
    issue(3, 8'hA8, 1, -1);
    idle(4);
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      issue(3, PW'(a * b), 1, -1);
      idle(1);
    end
    idle(4);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
